rvfi_commit_serializer: RTL and testbench
=========================================

# rvfi_commit_serializer

Sits between the core's multi-port RVFI commit interface and any single-stream trace consumer, such as an instruction tracer or a co-simulation checker. Each cycle it collects every commit-port record that has `valid` or `trap` set and compacts them in port order. It then buffers them in a FIFO and presents one record per handshake on a valid/ready output, tagging each with a 64-bit sequence number. Commit cannot be back-pressured, so on overflow records are dropped; the drop is flagged, counted and made visible as a gap in the sequence numbers.

## Interface
Parameters:
- NR_COMMIT_PORTS, 2: number of RVFI commit ports; legal range 1..4.
- DEPTH, 8: FIFO entries; power of two, at least 2*NR_COMMIT_PORTS.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- rvfi_i  in  rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0]  commit records from the core.
- flush_i  in  1  synchronous FIFO clear.
- rvfi_o  out  rvfi_pkg::rvfi_instr_t  head record; '0 when out_valid_o=0.
- out_valid_o  out  1  head record available.
- out_ready_i  in  1  consumer accepts the head record.
- order_o  out  64  sequence number of the head record; 0 when empty.
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow_o  out  1  sticky flag, set when any record has been dropped.
- drop_cnt_o  out  32  saturating count of dropped records.

## Operation
- Record definition: port p carries a record when rvfi_i[p].valid | rvfi_i[p].trap. Records are ordered by ascending p, and k is the number of records this cycle (0..NR_COMMIT_PORTS).
- Free space: free = DEPTH - level_o, using the registered level. A pop in the current cycle does not create space in the same cycle.
- Push: the first min(k, free) records, in port order, are written at consecutive write-pointer slots. Any remaining records are dropped.
- Sequence numbers: an internal 64-bit counter seq starts at 0. Each record is assigned seq+j by its rank j, whether it is accepted or dropped. seq advances by k each cycle, so drops appear as gaps in the sequence.
- Drops: if any record is dropped, overflow_o is set and stays set until reset. drop_cnt_o increases by the number dropped and saturates at 32'hFFFF_FFFF.
- Pop: the head is popped when out_valid_o & out_ready_i. The read pointer then advances by 1.
- Level: level_next = level + pushed - popped. Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Flush (flush_i=1) has priority over push and pop:
  - pointers and level clear to 0;
  - input records in the flush cycle are discarded, are not counted as drops and do not advance seq;
  - seq, overflow_o and drop_cnt_o keep their values.
- Output: out_valid_o = (level != 0). rvfi_o and order_o come from the head entry and are forced to '0 when the FIFO is empty. Stored records pass through unmodified.

## Timing
- Reset: out_valid_o=0, rvfi_o='0, order_o=0, level_o=0, overflow_o=0, drop_cnt_o=0; seq=0 and both pointers=0. Reset asserted mid-operation discards all FIFO contents immediately.
- Latency: a record sampled at rising edge N appears on rvfi_o with out_valid_o=1 after edge N, i.e. in cycle N+1 at the earliest.
- Throughput: at most one pop per cycle and up to NR_COMMIT_PORTS pushes per cycle.
- Handshake: while out_valid_o=1 and out_ready_i=0, rvfi_o and order_o stay stable. out_ready_i may be asserted while out_valid_o=0; it has no effect.
- Push and pop in the same cycle are both performed, using the level computed from registered values.
- Full boundary: with level=DEPTH, every incoming record is dropped even if a pop happens in that cycle.
- Empty boundary: with level=0 and a record arriving, out_valid_o is 0 in the arrival cycle and 1 in the next cycle. Records are never bypassed combinationally.

## Test plan
- Ordering: with out_ready_i=1, both ports valid in cycle 0 → port0 record (order 0) is output in cycle 1 and the port1 record (order 1) in cycle 2; level_o goes 2, 1, 0.
- Sparse: only port1 valid, with a trap and valid=0 on port0 → exactly one record is output, order 0; level_o peaks at 1.
- Overflow: DEPTH=8, out_ready_i=0, both ports valid for 5 cycles → level_o=8, overflow_o=1, drop_cnt_o=2. The next accepted record, after draining, has order 10.
- Partial accept: level_o=7 with 2 records arriving → the port0 record is stored, the port1 record is dropped; drop_cnt_o increases by 1 and level_o=8.
- Full plus pop: level_o=8, out_ready_i=1, 2 records arriving → both are dropped and level_o=7 in the next cycle.
- Flush and reset: flush_i while level_o=5 → level_o=0 and out_valid_o=0 in the next cycle, with seq and drop_cnt_o unchanged. Asserting rst_ni=0 mid-stream → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/rvfi_commit_serializer.sv
// Compacts multi-port RVFI commits into one FIFO-buffered, sequence-numbered stream.
// Latency 1 cycle, no bypass. Commit cannot stall: overflow records are dropped, flagged and counted.
package rvfi_pkg;
    typedef struct packed {
        logic        valid;
        logic        trap;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [1:0]  mode;
    } rvfi_instr_t;
endpackage

module rvfi_commit_serializer #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    input  logic                                     flush_i,
    output rvfi_pkg::rvfi_instr_t                    rvfi_o,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i,
    output logic [63:0]                              order_o,
    output logic [$clog2(DEPTH):0]                   level_o,
    output logic                                     overflow_o,
    output logic [31:0]                              drop_cnt_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    rvfi_pkg::rvfi_instr_t mem_q [DEPTH];
    logic [63:0]           ord_q [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [63:0]   seq_q, seq_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   drop_cnt_q, drop_cnt_d;

    logic          we    [NR_COMMIT_PORTS];
    logic [AW-1:0] waddr [NR_COMMIT_PORTS];
    logic [63:0]   word  [NR_COMMIT_PORTS];
    logic [LW-1:0] free, n_rec, n_push, n_drop;
    logic [32:0]   drop_sum;
    logic          pop;

    always_comb begin
        free   = LW'(DEPTH) - level_q;
        n_rec  = '0;
        n_push = '0;
        n_drop = '0;
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            we[p]    = 1'b0;
            waddr[p] = wptr_q + n_rec[AW-1:0];
            word[p]  = seq_q + 64'(n_rec);
            if (!flush_i && (rvfi_i[p].valid || rvfi_i[p].trap)) begin
                // Records are ranked in port order, so the first 'free' ranks are the accepted ones.
                if (n_rec < free) begin
                    we[p]  = 1'b1;
                    n_push = n_push + LW'(1);
                end else begin
                    n_drop = n_drop + LW'(1);
                end
                n_rec = n_rec + LW'(1);
            end
        end

        pop        = (level_q != '0) && out_ready_i && !flush_i;
        seq_d      = seq_q + 64'(n_rec);
        overflow_d = overflow_q || (n_drop != '0);
        drop_sum   = {1'b0, drop_cnt_q} + 33'(n_drop);
        drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];

        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            wptr_d  = wptr_q + n_push[AW-1:0];
            rptr_d  = rptr_q + AW'(pop);
            level_d = level_q + n_push - LW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: contents are only visible while level_q covers them.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (we[p]) begin
                mem_q[waddr[p]] <= rvfi_i[p];
                ord_q[waddr[p]] <= word[p];
            end
        end
    end

    assign out_valid_o = (level_q != '0);
    assign rvfi_o      = out_valid_o ? mem_q[rptr_q] : '0;
    assign order_o     = out_valid_o ? ord_q[rptr_q] : '0;
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;
endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Directed plus random stimulus against a queue scoreboard of expected records and order numbers.
module tb_rvfi_commit_serializer;
    import rvfi_pkg::*;
    localparam int NR = 2;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [63:0] ord;
        rvfi_instr_t rec;
    } entry_t;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    rvfi_instr_t [NR-1:0]     rvfi_i;
    logic                     flush_i = 1'b0;
    rvfi_instr_t              rvfi_o;
    logic                     out_valid_o;
    logic                     out_ready_i = 1'b0;
    logic [63:0]              order_o;
    logic [$clog2(DEPTH):0]   level_o;
    logic                     overflow_o;
    logic [31:0]              drop_cnt_o;

    rvfi_commit_serializer #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rvfi_i(rvfi_i), .flush_i(flush_i),
        .rvfi_o(rvfi_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .order_o(order_o), .level_o(level_o), .overflow_o(overflow_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_chk = 0;
    int          n_fail = 0;
    entry_t      sb [$];
    logic [63:0] m_seq = 0;
    logic [31:0] m_drops = 0;
    logic        m_ovf = 1'b0;
    rvfi_instr_t zero_rec = '0;
    rvfi_instr_t none = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input rvfi_instr_t obs, input rvfi_instr_t exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic rvfi_instr_t mk(input logic v, input logic t);
        rvfi_instr_t r;
        r          = '0;
        r.valid    = v;
        r.trap     = t;
        r.insn     = $urandom;
        r.pc_rdata = $urandom;
        r.pc_wdata = $urandom;
        r.rd_addr  = 5'($urandom);
        r.rd_wdata = $urandom;
        r.mode     = 2'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_seq   = 0;
        m_drops = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic check_outputs();
        chk("level", 64'(level_o), 64'(sb.size()));
        chk("out_valid", 64'(out_valid_o), 64'(sb.size() != 0));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drops));
        if (sb.size() != 0) begin
            chk("order", order_o, sb[0].ord);
            chk_rec("rvfi", rvfi_o, sb[0].rec);
        end else begin
            chk("order_empty", order_o, 64'd0);
            chk_rec("rvfi_empty", rvfi_o, zero_rec);
        end
    endtask

    // Called just after a falling edge: check, drive, update model, advance one cycle.
    task automatic step(input rvfi_instr_t r0, input rvfi_instr_t r1, input logic rdy, input logic fl);
        rvfi_instr_t rr [NR];
        int          n, free, j;
        logic        do_pop;
        check_outputs();
        rr[0] = r0;
        rr[1] = r1;
        rvfi_i[0]   = r0;
        rvfi_i[1]   = r1;
        out_ready_i = rdy;
        flush_i     = fl;
        n      = sb.size();
        do_pop = (n != 0) && rdy && !fl;
        if (fl) begin
            sb.delete();
        end else begin
            free = DEPTH - n;
            j    = 0;
            for (int p = 0; p < NR; p++) begin
                if (rr[p].valid || rr[p].trap) begin
                    if (j < free) sb.push_back('{ord: m_seq + 64'(j), rec: rr[p]});
                    else begin
                        m_drops++;
                        m_ovf = 1'b1;
                    end
                    j++;
                end
            end
            m_seq = m_seq + 64'(j);
            if (do_pop) void'(sb.pop_front());
        end
        #1;
        chk("no_bypass", 64'(out_valid_o), 64'(n != 0));
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rvfi_i = '0;
        @(negedge clk_i);
        do_reset();

        // Ordering
        step(mk(1, 0), mk(1, 0), 1'b1, 1'b0);
        chk("ord_lvl2", 64'(level_o), 64'd2);
        step(none, none, 1'b1, 1'b0);
        step(none, none, 1'b1, 1'b0);
        step(none, none, 1'b1, 1'b0);

        // Sparse: port1 only, then trap-only on port0
        do_reset();
        step(none, mk(1, 0), 1'b1, 1'b0);
        chk("sparse_order", order_o, 64'd0);
        step(none, none, 1'b1, 1'b0);
        step(mk(0, 1), none, 1'b0, 1'b0);
        step(none, none, 1'b1, 1'b0);
        step(none, none, 1'b1, 1'b0);

        // Overflow
        do_reset();
        repeat (5) step(mk(1, 0), mk(1, 1), 1'b0, 1'b0);
        chk("ovf_level", 64'(level_o), 64'd8);
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        chk("ovf_drops", 64'(drop_cnt_o), 64'd2);
        repeat (8) step(none, none, 1'b1, 1'b0);
        step(mk(1, 0), none, 1'b0, 1'b0);
        chk("gap_order", order_o, 64'd10);

        // Partial accept then full plus pop
        repeat (3) step(mk(1, 0), mk(1, 0), 1'b0, 1'b0);
        chk("pa_lvl7", 64'(level_o), 64'd7);
        step(mk(1, 0), mk(1, 0), 1'b0, 1'b0);
        chk("pa_lvl8", 64'(level_o), 64'd8);
        chk("pa_drops", 64'(drop_cnt_o), 64'd3);
        step(mk(1, 0), mk(1, 0), 1'b1, 1'b0);
        chk("fp_lvl7", 64'(level_o), 64'd7);
        chk("fp_drops", 64'(drop_cnt_o), 64'd5);

        // Flush at level 5
        repeat (2) step(none, none, 1'b1, 1'b0);
        chk("fl_lvl5", 64'(level_o), 64'd5);
        step(mk(1, 0), mk(1, 0), 1'b1, 1'b1);
        chk("fl_lvl0", 64'(level_o), 64'd0);
        chk("fl_valid", 64'(out_valid_o), 64'd0);
        chk("fl_drops", 64'(drop_cnt_o), 64'd5);
        step(mk(1, 0), none, 1'b0, 1'b0);
        chk("fl_seq", order_o, 64'd21);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            step(mk(1'($urandom), 1'($urandom)), mk(1'($urandom), 1'($urandom)),
                 1'($urandom), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-stream
        repeat (3) step(mk(1, 0), mk(1, 0), 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(mk(1, 0), none, 1'b1, 1'b0);
        chk("post_rst_order", order_o, 64'd0);
        step(none, none, 1'b1, 1'b0);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
